// File: rtl/z80_uart_pkg.sv
// Shared types for the UART receive path on the Z80 bus: bus structs,
// status-byte bit positions and the data-read state encoding.
package z80_uart_pkg;

    // Bus bundles as seen by a Z80 peripheral.
    typedef struct packed {
        logic       rdn;
        logic       wrn;
        logic [7:0] dmaster;
    } Z80MasterBus;

    typedef struct packed {
        logic [7:0] dslave;
        logic       mwait;
    } Z80SlaveBus;

    // Status byte bit positions.
    localparam int STAT_RDY  = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_OVR  = 2;

    // Data-port read sequencer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } rd_state_t;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Single-clock FIFO holding received bytes; DEPTH must be a power of two
// so the pointers wrap naturally. A pop frees a slot in the same cycle,
// so a push while full is accepted when it coincides with a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage write; contents need no reset since count guards every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer on the Z80 bus. Bytes from the receiver are queued in
// a FIFO; data-port reads stall with mwait until a byte is available and pop
// exactly one byte per bus cycle. The status port returns ready/full/overrun.
// Optional feature macro: UART_RX_FIFO_OVERRUN_EN (sticky overrun flag,
// cleared by the end of a status read).
module uart_rx_fifo
    import z80_uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    ena_stat,
    input  Z80MasterBus             ibus,
    output Z80SlaveBus              obus,
    input  logic                    rx_dv,
    input  logic [7:0]              rx_byte,
    output logic                    rx_ready,
    output logic [$clog2(DEPTH):0]  count
);
    rd_state_t  state;
    logic [7:0] data_q;
    logic [7:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       overrun;
    logic [7:0] status;
    logic       unused_bus;

    // Write data is never consumed by this read-only peripheral.
    assign unused_bus = ^ibus.dmaster;

    // Pop only from WAIT, so a byte pushed this cycle is seen one edge later.
    assign pop = (state == WAIT) && !fifo_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_dv),
        .pop   (pop),
        .din   (rx_byte),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign rx_ready = !fifo_empty;

    // Data-port read sequencer: one pop per bus read, hold until cycle ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            data_q <= 8'h00;
        end else begin
            case (state)
                IDLE: if (ena && !ibus.rdn) state <= WAIT;
                WAIT: if (!fifo_empty) begin
                    data_q <= fifo_dout;
                    state  <= HOLD;
                end
                HOLD: if (!ena || ibus.rdn) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_RX_FIFO_OVERRUN_EN
    logic stat_rd;
    logic stat_rd_q;
    logic drop;

    // ena has priority, so a doubly-decoded cycle is not a status read.
    assign stat_rd = ena_stat && !ena && !ibus.rdn;
    assign drop    = rx_dv && fifo_full && !pop;

    // Sticky overrun: set by a dropped byte, cleared as a status read ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun   <= 1'b0;
            stat_rd_q <= 1'b0;
        end else begin
            stat_rd_q <= stat_rd;
            if (drop)                       overrun <= 1'b1;
            else if (stat_rd_q && !stat_rd) overrun <= 1'b0;
        end
    end
`else
    assign overrun = 1'b0;
`endif

    // Status byte assembly.
    always_comb begin
        status            = 8'h00;
        status[STAT_RDY]  = !fifo_empty;
        status[STAT_FULL] = fifo_full;
        status[STAT_OVR]  = overrun;
    end

    assign obus.dslave = (ena_stat && !ena) ? status : data_q;
    // Reset releases the bus at once even if a read is still being driven.
    assign obus.mwait  = ~(rst_n && ena && !ibus.rdn && (state != HOLD));

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16).
module tb_uart_rx_fifo;
    import z80_uart_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        ena_stat;
    Z80MasterBus ibus;
    Z80SlaveBus  obus;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        rx_ready;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.DEPTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .ena_stat (ena_stat),
        .ibus     (ibus),
        .obus     (obus),
        .rx_dv    (rx_dv),
        .rx_byte  (rx_byte),
        .rx_ready (rx_ready),
        .count    (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic push_byte(input logic [7:0] b);
        rx_byte = b;
        rx_dv   = 1'b1;
        @(posedge clk); #1;
        rx_dv   = 1'b0;
    endtask

    task automatic read_data(output logic [7:0] d, output int waits);
        bit done;
        done  = 0;
        waits = 0;
        ena = 1'b1; ibus.rdn = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(posedge clk); #1;
            if (obus.mwait) done = 1;
            else waits++;
        end
        d = obus.dslave;
        ena = 1'b0; ibus.rdn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic read_status(output logic [7:0] s, output logic w);
        ena_stat = 1'b1; ibus.rdn = 1'b0;
        @(posedge clk); #1;
        s = obus.dslave;
        w = obus.mwait;
        ena_stat = 1'b0; ibus.rdn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic do_reset_pulse();
        #2 rst_n = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        ena = 1'b0; ena_stat = 1'b0; ibus.rdn = 1'b1; ibus.wrn = 1'b1; rx_dv = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++; if (obus.mwait !== 1'b1) begin errors++; $display("FAIL reset_mwait got %0b want 1", obus.mwait); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got %0b want 0", rx_ready); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (obus.dslave !== 8'h00) begin errors++; $display("FAIL reset_dslave got %02h want 00", obus.dslave); end
        release_reset();
    endtask

    task automatic test_single();
        logic [7:0] d;
        int w;
        push_byte(8'h41);
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL single_rx_ready got %0b want 1", rx_ready); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
        read_data(d, w);
        checks++; if (d !== 8'h41) begin errors++; $display("FAIL single_data got %02h want 41", d); end
        checks++; if (w != 1) begin errors++; $display("FAIL single_waits got %0d want 1", w); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_count_after got %0d want 0", count); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL single_rx_ready_after got %0b want 0", rx_ready); end
    endtask

    task automatic test_empty_read();
        ena = 1'b1; ibus.rdn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++; if (obus.mwait !== 1'b0) begin errors++; $display("FAIL empty_wait_%0d got %0b want 0", i, obus.mwait); end
        end
        push_byte(8'h5A);
        checks++; if (obus.mwait !== 1'b0) begin errors++; $display("FAIL empty_no_fallthrough got %0b want 0", obus.mwait); end
        @(posedge clk); #1;
        checks++; if (obus.mwait !== 1'b1) begin errors++; $display("FAIL empty_release got %0b want 1", obus.mwait); end
        checks++; if (obus.dslave !== 8'h5A) begin errors++; $display("FAIL empty_data got %02h want 5a", obus.dslave); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL empty_count got %0d want 0", count); end
        ena = 1'b0; ibus.rdn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill_overrun();
        logic [7:0] s;
        logic w;
        for (int i = 0; i < 20; i++) begin
            rx_byte = 8'(i);
            rx_dv   = 1'b1;
            @(posedge clk); #1;
        end
        rx_dv = 1'b0;
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count got %0d want 16", count); end
        read_status(s, w);
`ifdef UART_RX_FIFO_OVERRUN_EN
        checks++; if (s !== 8'h07) begin errors++; $display("FAIL fill_status got %02h want 07", s); end
`else
        checks++; if (s !== 8'h03) begin errors++; $display("FAIL fill_status got %02h want 03", s); end
`endif
        checks++; if (w !== 1'b1) begin errors++; $display("FAIL status_mwait got %0b want 1", w); end
        read_status(s, w);
        checks++; if (s !== 8'h03) begin errors++; $display("FAIL status_second got %02h want 03", s); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL status_no_pop got %0d want 16", count); end
    endtask

    task automatic test_pop_push_full();
        logic [7:0] d;
        logic [7:0] s;
        logic [7:0] exp;
        logic sw;
        int w;
        ena = 1'b1; ibus.rdn = 1'b0;
        @(posedge clk); #1;
        rx_byte = 8'hA5; rx_dv = 1'b1;
        @(posedge clk); #1;
        rx_dv = 1'b0;
        checks++; if (obus.dslave !== 8'h00) begin errors++; $display("FAIL pp_data got %02h want 00", obus.dslave); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL pp_count got %0d want 16", count); end
        ena = 1'b0; ibus.rdn = 1'b1;
        @(posedge clk); #1;
        read_status(s, sw);
        checks++; if (s !== 8'h03) begin errors++; $display("FAIL pp_status got %02h want 03", s); end
        for (int k = 0; k < 16; k++) begin
            exp = (k < 15) ? 8'(k + 1) : 8'hA5;
            read_data(d, w);
            checks++; if (d !== exp || w != 1) begin errors++; $display("FAIL drain_%0d got %02h/%0d want %02h/1", k, d, w, exp); end
        end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL drain_count got %0d want 0", count); end
    endtask

    task automatic test_write_ignored();
        push_byte(8'h33);
        ena = 1'b1; ibus.wrn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (obus.mwait !== 1'b1) begin errors++; $display("FAIL write_mwait_%0d got %0b want 1", i, obus.mwait); end
        end
        ena = 1'b0; ibus.wrn = 1'b1;
        @(posedge clk); #1;
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL write_count got %0d want 1", count); end
        do_reset_pulse();
        release_reset();
    endtask

    task automatic test_long_read_reset();
        push_byte(8'h11);
        push_byte(8'h22);
        ena = 1'b1; ibus.rdn = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL long_count got %0d want 1", count); end
        checks++; if (obus.dslave !== 8'h11) begin errors++; $display("FAIL long_data got %02h want 11", obus.dslave); end
        do_reset_pulse();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL long_rst_count got %0d want 0", count); end
        checks++; if (obus.mwait !== 1'b1) begin errors++; $display("FAIL long_rst_mwait got %0b want 1", obus.mwait); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL long_rst_ready got %0b want 0", rx_ready); end
        release_reset();
        ena = 1'b1; ibus.rdn = 1'b0;
        @(posedge clk); #1;
        checks++; if (obus.mwait !== 1'b0) begin errors++; $display("FAIL wait_before_rst got %0b want 0", obus.mwait); end
        do_reset_pulse();
        checks++; if (obus.mwait !== 1'b1) begin errors++; $display("FAIL wait_rst_mwait got %0b want 1", obus.mwait); end
        release_reset();
    endtask

    initial begin
        rst_n    = 1'b1;
        ena      = 1'b0;
        ena_stat = 1'b0;
        ibus     = '{rdn: 1'b1, wrn: 1'b1, dmaster: 8'h00};
        rx_dv    = 1'b0;
        rx_byte  = 8'h00;
        #2 rst_n = 1'b0;
        #20;
        test_reset();
        test_single();
        test_empty_read();
        test_fill_overrun();
        test_pop_push_full();
        test_write_ignored();
        test_long_read_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
